dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: the MIPS core's load/store port and a debug/loader port that the testbench or host uses to preload and inspect data memory.
- Sits between `mips_top`'s data-memory signals and the data-memory instance.
- Sequences each access through a small FSM and returns a stall to the core while a core access is pending.
- Fair round-robin grant between the two ports; one transaction in flight at a time.

Parameters:
- AW, 6: word-address width for both ports and the memory.
- DW, 32: data width.
- MEM_LATENCY, 1: cycles from the m_en cycle to the cycle m_rdata is valid. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  core access request (level); held until c_ack.
- c_we  in  1  core write enable; stable while c_req is high.
- c_addr  in  AW  core word address.
- c_wdata  in  DW  core write data.
- c_rdata  out  DW  core read data; valid in the c_ack cycle, held until the next core read completes.
- c_ack  out  1  one-cycle completion pulse to the core.
- c_stall  out  1  combinational: c_req & ~c_ack; freezes the core pipeline.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack: debug port, same widths and rules as the c_* signals (no stall output).
- m_en  out  1  memory access strobe, registered.
- m_we  out  1  memory write enable, registered; only meaningful with m_en.
- m_addr  out  AW  memory address, registered.
- m_wdata  out  DW  memory write data, registered.
- m_rdata  in  DW  memory read data; valid MEM_LATENCY cycles after the m_en cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - m_en, m_we, c_ack, d_ack and busy are 0.
  - m_addr, m_wdata, c_rdata and d_rdata are 0.
  - The round-robin pointer favours the core (last_grant=debug).
  - Asserting reset mid-transaction aborts it; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is high, remain in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port not granted last; update last_grant.
  - On a grant, latch we/addr/wdata into the m_* registers and go to ISSUE.
- ISSUE (one cycle): m_en=1, m_we=latched we.
  - Write: go to RESP.
  - Read: load cnt=MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - m_en=0.
  - When cnt==0, register m_rdata into the granted port's rdata and go to RESP.
  - Otherwise decrement cnt.
- RESP (one cycle): the granted port's ack=1; next state is IDLE.
- Timing, with the request first sampled in cycle t0:
  - m_en is high in t0+1.
  - Write ack is in t0+2.
  - Read ack is in t0+MEM_LATENCY+2, with rdata valid in the same cycle.
- Back-to-back: the requester drops or changes req on the edge after ack. The earliest next grant decision is the IDLE cycle after RESP, so the issue rate is one access per 3 cycles (write) or per MEM_LATENCY+3 cycles (read).
- Ack rules:
  - Ack is never asserted to a port that was not granted.
  - c_ack and d_ack are never high together.
- Protocol violation (req dropped before ack): the transaction still completes and ack still pulses; no error is flagged.
- A port's rdata changes only on that port's read completion; writes leave rdata unchanged.
- m_we is 0 whenever m_en is 0.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - Adds input port d_lock (1 bit).
  - While d_lock=1 in IDLE, the core is never granted and the debug port wins whenever d_req=1. The core stalls for as long as needed, so a burst preload cannot be interleaved with core traffic.
  - The round-robin pointer is not updated by locked grants.
  - d_lock has no effect on a transaction already past IDLE.
- Not defined: no d_lock port; pure round-robin as above.

Test Plan:
- Reset then a core write: c_req=1, c_we=1, c_addr=5, c_wdata=32'hDEADBEEF at t0 -> m_en=1, m_we=1, m_addr=5, m_wdata=32'hDEADBEEF at t0+1; c_ack=1 at t0+2; c_stall high t0..t0+1, low at t0+2.
- Core read with MEM_LATENCY=3, memory returning 32'h12345678 for addr 5 -> m_en at t0+1, c_ack and c_rdata=32'h12345678 at t0+5; d_ack stays 0.
- Simultaneous c_req and d_req (both reads) after reset -> core granted first (c_ack first); the debug port is granted in the next IDLE; with both held, grants alternate c,d,c,d over 4 transactions.
- Assert rst two cycles into a read -> m_en=0, busy=0 and no ack on the following edges; a new d_req after reset deassertion is served with normal timing.
- Debug write of 32'hA5A5A5A5 to addr 63 (the AW=6 boundary), then core read of addr 63 -> c_rdata=32'hA5A5A5A5; a later debug write leaves c_rdata unchanged.
- With DMEM_ARB_LOCK_EN defined: d_lock=1, d_req and c_req both held for 3 debug writes -> three d_acks and no c_ack; after d_lock=0, the core is granted at the next IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core and a debug/loader port.
// Optional DMEM_ARB_LOCK_EN adds d_lock, which lets the debug port hold off the core during a preload.
module dmem_arbiter #(
  parameter int AW          = 6,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_dbg_q, gnt_dbg_d;
  logic            last_dbg_q, last_dbg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m_en_q, m_en_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            lock_act;
  logic            pick_core, pick_dbg;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_act = d_lock;
`else
  assign lock_act = 1'b0;
`endif

  // last_dbg_q=1 means debug was served last, so the core wins a tie.
  assign pick_core = c_req & ~lock_act & (~d_req | last_dbg_q);
  assign pick_dbg  = d_req & (lock_act | ~c_req | ~last_dbg_q);

  always_comb begin
    state_d    = state_q;
    gnt_dbg_d  = gnt_dbg_q;
    last_dbg_d = last_dbg_q;
    cnt_d      = cnt_q;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_core || pick_dbg) begin
          gnt_dbg_d = pick_dbg;
          m_en_d    = 1'b1;
          m_we_d    = pick_dbg ? d_we    : c_we;
          m_addr_d  = pick_dbg ? d_addr  : c_addr;
          m_wdata_d = pick_dbg ? d_wdata : c_wdata;
          state_d   = ISSUE;
          // Locked grants leave the fairness pointer alone.
          if (pick_core)                 last_dbg_d = 1'b0;
          else if (!lock_act)            last_dbg_d = 1'b1;
        end
      end
      ISSUE: begin
        if (m_we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (gnt_dbg_q) d_rdata_d = m_rdata;
          else           c_rdata_d = m_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_dbg_q  <= 1'b0;
      last_dbg_q <= 1'b1;
      cnt_q      <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_dbg_q  <= gnt_dbg_d;
      last_dbg_q <= last_dbg_d;
      cnt_q      <= cnt_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign c_ack   = (state_q == RESP) & ~gnt_dbg_q;
  assign d_ack   = (state_q == RESP) &  gnt_dbg_q;
  assign c_stall = c_req & ~c_ack;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 3-cycle-latency behavioural memory.
module tb_dmem_arbiter;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          c_ack, d_ack, c_stall;
  logic          m_en, m_we, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          d_lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
`ifdef DMEM_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural memory: read data appears LAT cycles after the m_en cycle.
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [1:LAT];
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    rpipe[1] <= (m_en && !m_we) ? mem[m_addr] : 32'hBAD0BAD0;
    for (int k = 2; k <= LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign m_rdata = rpipe[LAT];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_xfer(input bit dbg, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                         output int lat, output bit wrong_ack);
    lat = -1; wrong_ack = 1'b0; rd = '0;
    if (dbg) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else     begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (dbg ? c_ack : d_ack) wrong_ack = 1'b1;
      if (dbg ? d_ack : c_ack) begin
        rd = dbg ? d_rdata : c_rdata; lat = n; break;
      end
    end
    if (dbg) d_req = 0; else c_req = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    checks++;
    if ({m_en, m_we, c_ack, d_ack, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {m_en, m_we, c_ack, d_ack, busy});
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || c_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h want 0", m_addr, m_wdata, c_rdata, d_rdata);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_core_write();
    c_req = 1; c_we = 1; c_addr = 6'd5; c_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (c_stall !== 1'b1) begin errors++; $display("FAIL wr_stall_t0: got %b want 1", c_stall); end
    tick();
    checks++;
    if ({m_en, m_we} !== 2'b11 || m_addr !== 6'd5 || m_wdata !== 32'hDEADBEEF || c_stall !== 1'b1 || c_ack !== 1'b0) begin
      errors++; $display("FAIL wr_issue: en=%b we=%b addr=%0d wdata=%h stall=%b ack=%b want 1 1 5 deadbeef 1 0",
                         m_en, m_we, m_addr, m_wdata, c_stall, c_ack);
    end
    tick();
    checks++;
    if (c_ack !== 1'b1 || c_stall !== 1'b0 || m_en !== 1'b0 || d_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack: ack=%b stall=%b en=%b dack=%b want 1 0 0 0", c_ack, c_stall, m_en, d_ack);
    end
    c_req = 0;
    tick();
    checks++;
    if (c_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_idle: ack=%b busy=%b want 0 0", c_ack, busy);
    end
  endtask

  task automatic test_core_read();
    logic [DW-1:0] rd; int lat; bit wa;
    do_xfer(1'b1, 1'b1, 6'd5, 32'h12345678, rd, lat, wa);
    checks++;
    if (lat != 2 || wa) begin errors++; $display("FAIL dbg_wr_lat: got %0d (wrong_ack=%b) want 2", lat, wa); end
    tick();
    c_req = 1; c_we = 0; c_addr = 6'd5;
    tick();
    checks++;
    if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 6'd5) begin
      errors++; $display("FAIL rd_issue: en=%b we=%b addr=%0d want 1 0 5", m_en, m_we, m_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if (c_ack !== (k == 5) || d_ack !== 1'b0) begin
        errors++; $display("FAIL rd_ack_t%0d: cack=%b dack=%b want %b 0", k, c_ack, d_ack, k == 5);
      end
    end
    checks++;
    if (c_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h want 12345678", c_rdata); end
    c_req = 0;
    tick();
  endtask

  task automatic test_round_robin();
    bit [3:0] seq = '0; int got = 0; bit both = 1'b0;
    rst = 1; tick(); rst = 0; tick();
    c_req = 1; c_we = 0; c_addr = 6'd5;
    d_req = 1; d_we = 0; d_addr = 6'd5;
    for (int n = 0; n < 80 && got < 4; n++) begin
      tick();
      if (c_ack && d_ack) both = 1'b1;
      if (c_ack)      begin seq[got] = 1'b0; got++; end
      else if (d_ack) begin seq[got] = 1'b1; got++; end
    end
    c_req = 0; d_req = 0;
    checks++;
    if (got != 4 || seq !== 4'b1010 || both) begin
      errors++; $display("FAIL rr_order: got %0d acks seq=%b both=%b want 4 1010 0", got, seq, both);
    end
    checks++;
    if (c_rdata !== 32'h12345678 || d_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rr_data: crd=%h drd=%h want 12345678", c_rdata, d_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] rd; int lat; bit wa;
    c_req = 1; c_we = 0; c_addr = 6'd5;
    tick(); tick();
    rst = 1; #1;
    checks++;
    if (busy !== 1'b0 || m_en !== 1'b0) begin
      errors++; $display("FAIL abort_now: busy=%b en=%b want 0 0", busy, m_en);
    end
    c_req = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (c_ack !== 1'b0 || d_ack !== 1'b0 || m_en !== 1'b0) begin
        errors++; $display("FAIL abort_hold%0d: cack=%b dack=%b en=%b want 0 0 0", k, c_ack, d_ack, m_en);
      end
    end
    rst = 0;
    checks++;
    if (c_rdata !== '0) begin errors++; $display("FAIL abort_crd: got %h want 0", c_rdata); end
    tick();
    do_xfer(1'b1, 1'b0, 6'd5, '0, rd, lat, wa);
    checks++;
    if (lat != 5 || wa || rd !== 32'h12345678) begin
      errors++; $display("FAIL abort_after: lat=%0d wa=%b rd=%h want 5 0 12345678", lat, wa, rd);
    end
    tick();
  endtask

  task automatic test_boundary();
    logic [DW-1:0] rd; int lat; bit wa;
    do_xfer(1'b1, 1'b1, 6'd63, 32'hA5A5A5A5, rd, lat, wa);
    tick();
    do_xfer(1'b0, 1'b0, 6'd63, '0, rd, lat, wa);
    checks++;
    if (lat != 5 || wa || rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bnd_read: lat=%0d wa=%b rd=%h want 5 0 a5a5a5a5", lat, wa, rd);
    end
    tick();
    do_xfer(1'b1, 1'b1, 6'd63, 32'h11111111, rd, lat, wa);
    checks++;
    if (c_rdata !== 32'hA5A5A5A5 || d_rdata !== 32'h12345678 || lat != 2) begin
      errors++; $display("FAIL bnd_hold: crd=%h drd=%h lat=%0d want a5a5a5a5 12345678 2", c_rdata, d_rdata, lat);
    end
    tick();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    int nd = 0, nc = 0, lat = -1;
    d_lock = 1;
    d_req = 1; d_we = 1; d_addr = 6'd2; d_wdata = 32'h0000_00D0;
    c_req = 1; c_we = 1; c_addr = 6'd1; c_wdata = 32'h0000_0077;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (c_ack) nc++;
      if (d_ack) begin
        nd++;
        if (nd == 3) begin d_lock = 0; d_req = 0; break; end
        d_addr = 6'(2 + nd);
      end
    end
    checks++;
    if (nd != 3 || nc != 0) begin errors++; $display("FAIL lock_burst: dacks=%0d cacks=%0d want 3 0", nd, nc); end
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (c_ack) begin lat = n; break; end
    end
    c_req = 0;
    checks++;
    if (lat != 3) begin errors++; $display("FAIL lock_release: core ack after %0d want 3", lat); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_core_write();
    test_core_read();
    test_round_robin();
    test_reset_abort();
    test_boundary();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
